// File: rtl/drone_fluxo_dados.sv
// Datapath for the drone game: position, move timer, map select and lives.
// Returns the status events that the control FSM waits on.
module drone_fluxo_dados #(
  parameter int                   MAP_LEN        = 16,
  parameter int                   TIMEOUT_CYCLES = 1000,
  parameter int                   LANE_INICIAL   = 1,
  parameter logic [4*MAP_LEN-1:0] MAPA0          = 64'h0240_1880_0610_2440,
  parameter logic [4*MAP_LEN-1:0] MAPA1          = 64'h4182_2418_8124_1820
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       zeraPosicoes,
  input  logic                       contaT,
  input  logic                       zeraT,
  input  logic                       escolhe_modo,
  input  logic                       escolhe_vida,
  input  logic                       resetaVidas,
  input  logic                       confirma,
  input  logic                       desloca,
  input  logic                       checa_colisao_out,
  input  logic                       sel_modo,
  input  logic [1:0]                 sel_vidas,
  input  logic [1:0]                 botoes,
  output logic                       borda_movimento,
  output logic                       timeout,
  output logic                       colisao,
  output logic                       fim_mapa,
  output logic [$clog2(MAP_LEN)-1:0] db_coluna,
  output logic [1:0]                 db_faixa,
  output logic [1:0]                 db_vidas,
  output logic                       db_modo
);

  localparam int CW = $clog2(MAP_LEN);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(MAP_LEN - 1);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0]        coluna;
  logic [1:0]           faixa;
  logic [TW-1:0]        timer;
  logic [1:0]           vidas;
  logic                 modo;
  logic [1:0]           botoes_prev;
  logic                 borda_r;
  logic [1:0]           rise;
  logic                 move_ok;
  logic                 obst;
  logic [4*MAP_LEN-1:0] mapa;
  logic [1:0]           vidas_sel;

  always_comb begin
    rise      = botoes & ~botoes_prev;
    move_ok   = desloca && (rise != 2'b00);
    mapa      = modo ? MAPA1 : MAPA0;
    obst      = mapa[{coluna, faixa}];
    vidas_sel = (sel_vidas == 2'd0) ? 2'd1 : sel_vidas;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_prev <= '0;
    end else begin
      botoes_prev <= botoes;
    end
  end

  // Both buttons rising together still advances the column with the lane kept.
  always_ff @(posedge clock) begin
    if (reset) begin
      coluna <= '0;
      faixa  <= 2'(LANE_INICIAL);
    end else if (zeraPosicoes) begin
      coluna <= '0;
      faixa  <= 2'(LANE_INICIAL);
    end else if (move_ok) begin
      if (coluna != COL_MAX) coluna <= coluna + 1'b1;
      case (rise)
        2'b10:   if (faixa != 2'd3) faixa <= faixa + 2'd1;
        2'b01:   if (faixa != 2'd0) faixa <= faixa - 2'd1;
        default: faixa <= faixa;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      borda_r <= 1'b0;
    end else begin
      borda_r <= move_ok & ~zeraPosicoes;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
    end else if (zeraT) begin
      timer <= '0;
    end else if (contaT && (timer != T_MAX)) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vidas <= 2'd1;
    end else if (resetaVidas) begin
      vidas <= 2'd1;
    end else if (escolhe_vida && confirma) begin
      vidas <= vidas_sel;
    end else if (checa_colisao_out && obst && (vidas > 2'd1)) begin
      vidas <= vidas - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      modo <= 1'b0;
    end else if (escolhe_modo && confirma) begin
      modo <= sel_modo;
    end
  end

  always_comb begin
    borda_movimento = borda_r;
    timeout         = (timer == T_MAX);
    colisao         = obst && (vidas <= 2'd1);
    fim_mapa        = (coluna == COL_MAX);
    db_coluna       = coluna;
    db_faixa        = faixa;
    db_vidas        = vidas;
    db_modo         = modo;
  end

endmodule
